// File: rtl/rob_pkg.sv
// Shared types and helpers for the reorder buffer.
// Entry widths follow the package defaults; keep top-level parameters in step.
package rob_pkg;
  localparam int REG_ADDR_WIDTH_DEF = 5;
  localparam int Q_WIDTH_DEF        = 5;
  localparam int DEPTH_DEF          = 16;
  localparam int DATA_W             = 32;

  // Tag 0 means "no producer"; real tags run 1..DEPTH.
  localparam int TAG_NONE = 0;

  typedef struct packed {
    logic                          busy;
    logic                          ready;
    logic                          has_rd;
    logic [REG_ADDR_WIDTH_DEF-1:0] rd;
    logic [DATA_W-1:0]             value;
  } rob_entry_t;

  // Advance a tag/pointer, wrapping depth -> 1 so tag 0 is never produced.
  function automatic logic [Q_WIDTH_DEF-1:0] tag_next(input logic [Q_WIDTH_DEF-1:0] tag,
                                                      input int unsigned depth = DEPTH_DEF);
    if (32'(tag) >= depth) return Q_WIDTH_DEF'(1);
    return tag + 1'b1;
  endfunction
endpackage

// File: rtl/rob_query_port.sv
// Operand-readiness lookup for one source operand, with CDB bypass.
module rob_query_port
  import rob_pkg::*;
#(
  parameter int Q_WIDTH = Q_WIDTH_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic [Q_WIDTH-1:0]          query_tag,
  input  logic                        cdb_valid,
  input  logic [Q_WIDTH-1:0]          cdb_tag,
  input  logic [DATA_W-1:0]           cdb_value,
  input  logic [DEPTH:0]              ent_ready,
  input  logic [DEPTH:0][DATA_W-1:0]  ent_value,
  output logic                        q_ready,
  output logic [DATA_W-1:0]           q_value
);
  // Tag 0 never resolves; a same-cycle broadcast wins over the stored entry.
  always_comb begin
    q_ready = 1'b0;
    q_value = '0;
    if (32'(query_tag) != TAG_NONE) begin
      if (cdb_valid && cdb_tag == query_tag) begin
        q_ready = 1'b1;
        q_value = cdb_value;
      end else if (32'(query_tag) <= DEPTH) begin
        q_ready = ent_ready[query_tag];
        q_value = ent_value[query_tag];
      end
    end
  end
endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tag allocation/rename, CDB capture, in-order commit.
// Optional feature: define ROB_FLUSH_EN to add the flush_in port.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int Q_WIDTH        = Q_WIDTH_DEF,
  parameter int DEPTH          = DEPTH_DEF
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
`ifdef ROB_FLUSH_EN
  input  logic                      flush_in,
`endif
  input  logic                      rdy_in,
  input  logic                      issue_valid,
  input  logic                      issue_has_rd,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  output logic                      issue_ready,
  output logic [Q_WIDTH-1:0]        issue_tag,
  output logic                      rd_control,
  output logic [REG_ADDR_WIDTH-1:0] rd,
  output logic [Q_WIDTH-1:0]        Q_value,
  input  logic                      cdb_valid,
  input  logic [Q_WIDTH-1:0]        cdb_tag,
  input  logic [31:0]               cdb_value,
  input  logic [Q_WIDTH-1:0]        query1_tag,
  input  logic [Q_WIDTH-1:0]        query2_tag,
  output logic                      q1_ready,
  output logic [31:0]               q1_value,
  output logic                      q2_ready,
  output logic [31:0]               q2_value,
  output logic                      has_commit,
  output logic [REG_ADDR_WIDTH-1:0] commit_target,
  output logic [Q_WIDTH-1:0]        Commit_Q,
  output logic [31:0]               Commit_V
);
  localparam int NUM_QP = 2;

  rob_entry_t                 ent [1:DEPTH];
  logic [Q_WIDTH-1:0]         head, tail, count;
  logic [DEPTH:0]             busy_vec, ready_vec;
  logic [DEPTH:0][DATA_W-1:0] value_vec;
  logic                       flush, accept, pop, cdb_wr;

`ifdef ROB_FLUSH_EN
  assign flush = flush_in & rdy_in;
`else
  assign flush = 1'b0;
`endif

  // Flatten entry state into tag-indexed vectors; index 0 is the null tag.
  assign busy_vec[0]  = 1'b0;
  assign ready_vec[0] = 1'b0;
  assign value_vec[0] = '0;
  for (genvar i = 1; i <= DEPTH; i++) begin : g_vec
    assign busy_vec[i]  = ent[i].busy;
    assign ready_vec[i] = ent[i].ready;
    assign value_vec[i] = ent[i].value;
  end

  assign issue_ready = 32'(count) < DEPTH;
  assign issue_tag   = tail;
  assign accept      = issue_valid && issue_ready && rdy_in && !flush;
  assign rd_control  = accept && issue_has_rd && (issue_rd != '0);
  assign rd          = issue_rd;
  assign Q_value     = tail;

  // Only busy entries capture a broadcast; the slot being allocated is not yet busy.
  assign cdb_wr = rdy_in && !flush && cdb_valid && (32'(cdb_tag) != TAG_NONE) &&
                  (32'(cdb_tag) <= DEPTH) && busy_vec[cdb_tag];
  assign pop    = rdy_in && !flush && (count != '0) && ready_vec[head];

  // Entry array, pointers and occupancy.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 1; i <= DEPTH; i++) ent[i] <= '0;
      head  <= Q_WIDTH'(1);
      tail  <= Q_WIDTH'(1);
      count <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        for (int i = 1; i <= DEPTH; i++) ent[i] <= '0;
        head  <= Q_WIDTH'(1);
        tail  <= Q_WIDTH'(1);
        count <= '0;
      end else begin
        if (cdb_wr) begin
          ent[cdb_tag].ready <= 1'b1;
          ent[cdb_tag].value <= cdb_value;
        end
        if (pop) begin
          ent[head].busy  <= 1'b0;
          ent[head].ready <= 1'b0;
          head <= Q_WIDTH'(tag_next(Q_WIDTH_DEF'(head), DEPTH));
        end
        if (accept) begin
          ent[tail].busy   <= 1'b1;
          ent[tail].ready  <= 1'b0;
          ent[tail].has_rd <= issue_has_rd;
          ent[tail].rd     <= REG_ADDR_WIDTH_DEF'(issue_rd);
          ent[tail].value  <= '0;
          tail <= Q_WIDTH'(tag_next(Q_WIDTH_DEF'(tail), DEPTH));
        end
        case ({accept, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Registered commit port toward the register file.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      has_commit    <= 1'b0;
      commit_target <= '0;
      Commit_Q      <= '0;
      Commit_V      <= '0;
    end else if (rdy_in) begin
      if (pop) begin
        has_commit    <= ent[head].has_rd && (ent[head].rd != '0);
        commit_target <= REG_ADDR_WIDTH'(ent[head].rd);
        Commit_Q      <= head;
        Commit_V      <= ent[head].value;
      end else begin
        has_commit    <= 1'b0;
      end
    end
  end

  // Two identical operand lookup ports.
  logic [NUM_QP-1:0][Q_WIDTH-1:0] qp_tag;
  logic [NUM_QP-1:0]              qp_ready;
  logic [NUM_QP-1:0][DATA_W-1:0]  qp_value;

  assign qp_tag = {query2_tag, query1_tag};

  for (genvar p = 0; p < NUM_QP; p++) begin : g_qp
    rob_query_port #(.Q_WIDTH(Q_WIDTH), .DEPTH(DEPTH)) u_qp (
      .query_tag (qp_tag[p]),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_value (cdb_value),
      .ent_ready (ready_vec),
      .ent_value (value_vec),
      .q_ready   (qp_ready[p]),
      .q_value   (qp_value[p])
    );
  end

  assign q1_ready = qp_ready[0];
  assign q1_value = qp_value[0];
  assign q2_ready = qp_ready[1];
  assign q2_value = qp_value[1];
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed, table-driven bench for reorder_buffer.
module tb_reorder_buffer;
  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        issue_valid, issue_has_rd;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  issue_tag;
  logic        rd_control;
  logic [4:0]  rd;
  logic [4:0]  Q_value;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic [4:0]  query1_tag, query2_tag;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_value, q2_value;
  logic        has_commit;
  logic [4:0]  commit_target;
  logic [4:0]  Commit_Q;
  logic [31:0] Commit_V;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_in = ~clk_in;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_has_rd(issue_has_rd), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .issue_tag(issue_tag),
    .rd_control(rd_control), .rd(rd), .Q_value(Q_value),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .query1_tag(query1_tag), .query2_tag(query2_tag),
    .q1_ready(q1_ready), .q1_value(q1_value), .q2_ready(q2_ready), .q2_value(q2_value),
    .has_commit(has_commit), .commit_target(commit_target),
    .Commit_Q(Commit_Q), .Commit_V(Commit_V)
  );

  typedef struct {
    bit rst; bit rdy; bit iv; bit ihr; logic [4:0] ird;
    bit cv; logic [4:0] ct; logic [31:0] cval; logic [4:0] q1; logic [4:0] q2;
    bit e_ir; logic [4:0] e_itag; bit e_rc;
    bit e_q1r; logic [31:0] e_q1v; bit e_q2r; logic [31:0] e_q2v;
    bit e_hc; logic [4:0] e_ct; logic [4:0] e_cq; logic [31:0] e_cv;
  } vec_t;

  function automatic vec_t mk(bit rst, bit iv, bit ihr, logic [4:0] ird,
                              bit cv, logic [4:0] ct, logic [31:0] cval,
                              logic [4:0] q1, logic [4:0] q2,
                              bit e_ir, logic [4:0] e_itag, bit e_rc,
                              bit e_q1r, logic [31:0] e_q1v, bit e_q2r, logic [31:0] e_q2v,
                              bit e_hc, logic [4:0] e_ct, logic [4:0] e_cq, logic [31:0] e_cv);
    vec_t v;
    v.rst = rst; v.rdy = 1'b1; v.iv = iv; v.ihr = ihr; v.ird = ird;
    v.cv = cv; v.ct = ct; v.cval = cval; v.q1 = q1; v.q2 = q2;
    v.e_ir = e_ir; v.e_itag = e_itag; v.e_rc = e_rc;
    v.e_q1r = e_q1r; v.e_q1v = e_q1v; v.e_q2r = e_q2r; v.e_q2v = e_q2v;
    v.e_hc = e_hc; v.e_ct = e_ct; v.e_cq = e_cq; v.e_cv = e_cv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Drive one vector after the falling edge, check mid-cycle, then take the rising edge.
  task automatic run_vec(input vec_t v, input string id);
    @(negedge clk_in);
    if (v.rst) begin
      rst_n_in = 1'b0;
      #1 rst_n_in = 1'b1;
    end
    rdy_in = v.rdy; issue_valid = v.iv; issue_has_rd = v.ihr; issue_rd = v.ird;
    cdb_valid = v.cv; cdb_tag = v.ct; cdb_value = v.cval;
    query1_tag = v.q1; query2_tag = v.q2;
    #1;
    chk({id, " issue_ready"}, 32'(issue_ready), 32'(v.e_ir));
    chk({id, " issue_tag"},   32'(issue_tag),   32'(v.e_itag));
    chk({id, " rd_control"},  32'(rd_control),  32'(v.e_rc));
    if (v.e_rc) begin
      chk({id, " rd"},      32'(rd),      32'(v.ird));
      chk({id, " Q_value"}, 32'(Q_value), 32'(v.e_itag));
    end
    chk({id, " q1_ready"}, 32'(q1_ready), 32'(v.e_q1r));
    chk({id, " q1_value"}, q1_value,      v.e_q1v);
    chk({id, " q2_ready"}, 32'(q2_ready), 32'(v.e_q2r));
    chk({id, " q2_value"}, q2_value,      v.e_q2v);
    chk({id, " has_commit"}, 32'(has_commit), 32'(v.e_hc));
    if (v.e_hc) begin
      chk({id, " commit_target"}, 32'(commit_target), 32'(v.e_ct));
      chk({id, " Commit_Q"},      32'(Commit_Q),      32'(v.e_cq));
      chk({id, " Commit_V"},      Commit_V,           v.e_cv);
    end
    @(posedge clk_in);
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1;
    issue_valid = 1'b0; issue_has_rd = 1'b0; issue_rd = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    query1_tag = '0; query2_tag = '0;
    repeat (2) @(negedge clk_in);
    #1;
    chk("reset has_commit",    32'(has_commit),    0);
    chk("reset commit_target", 32'(commit_target), 0);
    chk("reset Commit_Q",      32'(Commit_Q),      0);
    chk("reset Commit_V",      Commit_V,           0);
    rst_n_in = 1'b1;
    #1;
    chk("reset issue_ready", 32'(issue_ready), 1);
    chk("reset issue_tag",   32'(issue_tag),   1);

    // Single issue -> complete -> commit.
    tbl.push_back(mk(1,1,1,5, 0,0,0,           0,0, 1,1,1, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,1,32'hDEADBEEF,1,0, 1,2,0, 1,32'hDEADBEEF,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,           1,0, 1,2,0, 1,32'hDEADBEEF,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,           0,0, 1,2,0, 0,0,0,0, 1,5,1,32'hDEADBEEF));
    tbl.push_back(mk(0,0,0,0, 0,0,0,           0,0, 1,2,0, 0,0,0,0, 0,0,0,0));
    // Out-of-order completion, in-order retirement.
    tbl.push_back(mk(1,1,1,1, 0,0,0,     0,0, 1,1,1, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,1,2, 0,0,0,     0,0, 1,2,1, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,1,3, 0,0,0,     0,0, 1,3,1, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,3,32'h33,0,0, 1,4,0, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,2,32'h22,0,3, 1,4,0, 0,0,1,32'h33, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,1,32'h11,1,0, 1,4,0, 1,32'h11,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,     0,0, 1,4,0, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,     0,0, 1,4,0, 0,0,0,0, 1,1,1,32'h11));
    tbl.push_back(mk(0,0,0,0, 0,0,0,     0,0, 1,4,0, 0,0,0,0, 1,2,2,32'h22));
    tbl.push_back(mk(0,0,0,0, 0,0,0,     0,0, 1,4,0, 0,0,0,0, 1,3,3,32'h33));
    tbl.push_back(mk(0,0,0,0, 0,0,0,     0,0, 1,4,0, 0,0,0,0, 0,0,0,0));
    // Query bypass vs. tag 0; a broadcast to a non-busy tag is not captured.
    tbl.push_back(mk(1,0,0,0, 1,4,32'h11,4,0, 1,1,0, 1,32'h11,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,     4,4, 1,1,0, 0,0,0,0, 0,0,0,0));
    // rd=0 and no-destination instructions retire silently.
    tbl.push_back(mk(1,1,1,0, 0,0,0, 0,0, 1,1,0, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,0,7, 0,0,0, 0,0, 1,2,0, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,1,1, 0,0, 1,3,0, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,2,2, 0,0, 1,3,0, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 1,3,0, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 1,3,0, 0,0,0,0, 0,0,0,0));

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("v%0d", i));

    // Fill all 16 entries, reject the 17th, retire one, wrap the tail.
    for (int i = 1; i <= 16; i++)
      run_vec(mk(i == 1,1,1,5'(i), 0,0,0, 0,0, 1,5'(i),1, 0,0,0,0, 0,0,0,0), $sformatf("fill%0d", i));
    run_vec(mk(0,1,1,20, 1,1,32'h55, 0,0, 0,1,0, 0,0,0,0, 0,0,0,0), "full_blocked");
    run_vec(mk(0,1,1,20, 0,0,0,      0,0, 0,1,0, 0,0,0,0, 0,0,0,0), "full_pop_same_cycle");
    run_vec(mk(0,1,1,21, 0,0,0,      0,0, 1,1,1, 0,0,0,0, 1,1,1,32'h55), "wrap_issue");
    run_vec(mk(0,0,0,0,  0,0,0,      0,0, 0,2,0, 0,0,0,0, 0,0,0,0), "refull");

    // Stall with a pending commit held on the outputs.
    run_vec(mk(1,1,1,9, 0,0,0,     0,0, 1,1,1, 0,0,0,0, 0,0,0,0), "stall_issue");
    run_vec(mk(0,0,0,0, 1,1,32'hAB,0,0, 1,2,0, 0,0,0,0, 0,0,0,0), "stall_cdb");
    run_vec(mk(0,0,0,0, 0,0,0,     0,0, 1,2,0, 0,0,0,0, 0,0,0,0), "stall_pop");
    for (int i = 0; i < 3; i++) begin
      v = mk(0,1,1,3, 1,2,32'h77, 0,0, 1,2,0, 0,0,0,0, 1,9,1,32'hAB);
      v.rdy = 1'b0;
      run_vec(v, $sformatf("stall%0d", i));
    end
    run_vec(mk(0,0,0,0, 0,0,0,     0,0, 1,2,0, 0,0,0,0, 1,9,1,32'hAB), "stall_release");
    run_vec(mk(0,1,1,4, 0,0,0,     0,0, 1,2,1, 0,0,0,0, 0,0,0,0), "pre_rst_issue");
    run_vec(mk(0,0,0,0, 1,2,32'hCD,0,0, 1,3,0, 0,0,0,0, 0,0,0,0), "pre_rst_cdb");
    run_vec(mk(0,1,1,6, 0,0,0,     0,0, 1,3,1, 0,0,0,0, 0,0,0,0), "pre_rst_pop");

    // Asynchronous reset between clock edges takes effect immediately.
    @(negedge clk_in);
    issue_valid = 1'b0; cdb_valid = 1'b0;
    #1;
    chk("pre_rst has_commit", 32'(has_commit), 1);
    chk("pre_rst issue_tag",  32'(issue_tag),  4);
    #1 rst_n_in = 1'b0;
    #1;
    chk("async_rst has_commit",  32'(has_commit),  0);
    chk("async_rst issue_tag",   32'(issue_tag),   1);
    chk("async_rst issue_ready", 32'(issue_ready), 1);
    chk("async_rst Commit_V",    Commit_V,         0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    run_vec(mk(0,0,0,0, 0,0,0, 0,0, 1,1,0, 0,0,0,0, 0,0,0,0), "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end
endmodule
